// File: rtl/siso_layer_scheduler_pkg.sv
// Shared definitions for the SISO layer scheduler, the row unit and the E-memory.
// Holds the default geometry and the scheduler FSM state encoding.
package siso_layer_scheduler_pkg;

   localparam int LAYERS_DEF    = 2;
   localparam int LAYERBITS_DEF = 1;
   localparam int ADDRWIDTH_DEF = 5;
   localparam int ADDRDEPTH_DEF = 20;
   localparam int ITERWIDTH_DEF = 5;
   localparam int CNTWIDTH_DEF  = 6;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t ST_IDLE  = 2'd0;
   localparam sched_state_t ST_ISSUE = 2'd1;
   localparam sched_state_t ST_WAIT  = 2'd2;
   localparam sched_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/siso_outstanding_cnt.sv
// Up/down counter of reads in flight through the row unit pipeline.
// Reports whether the count will be zero after this cycle's update, and
// raises a sticky flag if a write returns while nothing is outstanding.
module siso_outstanding_cnt #(
   parameter int CNTWIDTH = 6
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_next_zero,
   output logic o_err_underflow
);

   logic [CNTWIDTH-1:0] r_count;
   logic                r_underflow;
   logic [CNTWIDTH-1:0] w_next;
   logic                w_under;

   // Next count: simultaneous inc and dec cancel; a dec at zero saturates and flags
   always_comb begin
      w_next  = r_count;
      w_under = 1'b0;
      if (i_inc && !i_dec) begin
         w_next = r_count + CNTWIDTH'(1);
      end else if (!i_inc && i_dec) begin
         if (r_count == '0) begin
            w_under = 1'b1;
         end else begin
            w_next = r_count - CNTWIDTH'(1);
         end
      end
   end

   // Count register and sticky underflow flag, cleared only by reset
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_count <= w_next;
         if (w_under) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign o_next_zero     = (w_next == '0);
   assign o_err_underflow = r_underflow;

endmodule

// File: rtl/siso_layer_scheduler.sv
// Layered-decoding scheduler for the pipelined SISO row unit.
// Streams one burst of read addresses per layer and holds the next layer
// until every write of the previous layer has come back from the pipeline.
module siso_layer_scheduler
   import siso_layer_scheduler_pkg::*;
#(
   parameter int LAYERS    = LAYERS_DEF,
   parameter int LAYERBITS = LAYERBITS_DEF,
   parameter int ADDRWIDTH = ADDRWIDTH_DEF,
   parameter int ADDRDEPTH = ADDRDEPTH_DEF,
   parameter int ITERWIDTH = ITERWIDTH_DEF,
   parameter int CNTWIDTH  = CNTWIDTH_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [ITERWIDTH-1:0] i_max_iter,
   input  logic                 i_wren_in,
   output logic [LAYERBITS-1:0] o_rdlayer_regout,
   output logic [ADDRWIDTH-1:0] o_rdaddress_regout,
   output logic                 o_rden_LLR_regout,
   output logic                 o_rden_E_regout,
   output logic [ITERWIDTH-1:0] o_iter_count,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err_underflow
);

   sched_state_t         r_state;
   logic [LAYERBITS-1:0] r_layer;
   logic [ADDRWIDTH-1:0] r_addr;
   logic [ITERWIDTH-1:0] r_iter;
   logic                 r_abort;
   logic                 r_rden;
   logic [LAYERBITS-1:0] r_rdlayer;
   logic [ADDRWIDTH-1:0] r_rdaddr;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_drained;
   logic                 w_lastAddr;
   logic                 w_lastLayer;
   logic                 w_abortSeen;
   logic [ITERWIDTH-1:0] w_iterNext;
   logic [ITERWIDTH-1:0] w_target;

   // Every issued read is a pending write until the row unit's wren returns
   siso_outstanding_cnt #(
      .CNTWIDTH(CNTWIDTH)
   ) u_outstanding (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_inc          (r_rden),
      .i_dec          (i_wren_in),
      .o_next_zero    (w_drained),
      .o_err_underflow(o_err_underflow)
   );

   assign w_lastAddr  = (r_addr == ADDRWIDTH'(ADDRDEPTH - 1));
   assign w_lastLayer = (r_layer == LAYERBITS'(LAYERS - 1));
   assign w_abortSeen = r_abort | i_abort;
   assign w_iterNext  = r_iter + ITERWIDTH'(1);
   assign w_target    = (i_max_iter == '0) ? ITERWIDTH'(1) : i_max_iter;

   // Scheduler FSM with registered read stream, iteration count and status outputs
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= ST_IDLE;
         r_layer   <= '0;
         r_addr    <= '0;
         r_iter    <= '0;
         r_abort   <= 1'b0;
         r_rden    <= 1'b0;
         r_rdlayer <= '0;
         r_rdaddr  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_rden <= 1'b0;
         r_done <= 1'b0;
         if ((r_state == ST_ISSUE || r_state == ST_WAIT) && i_abort) begin
            r_abort <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               r_abort <= 1'b0;
               if (i_start) begin
                  r_state <= ST_ISSUE;
                  r_busy  <= 1'b1;
                  r_iter  <= '0;
                  r_layer <= '0;
                  r_addr  <= '0;
               end
            end
            ST_ISSUE: begin
               r_rden    <= 1'b1;
               r_rdlayer <= r_layer;
               r_rdaddr  <= r_addr;
               if (w_lastAddr) begin
                  r_addr  <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_addr <= r_addr + ADDRWIDTH'(1);
               end
            end
            ST_WAIT: begin
               if (w_drained) begin
                  if (!w_lastLayer) begin
                     if (w_abortSeen) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_layer <= r_layer + LAYERBITS'(1);
                        r_state <= ST_ISSUE;
                     end
                  end else begin
                     r_iter  <= w_iterNext;
                     r_layer <= '0;
                     if (w_iterNext == w_target || w_abortSeen) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_ISSUE;
                     end
                  end
               end
            end
            ST_DONE: begin
               r_abort <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rdlayer_regout   = r_rdlayer;
   assign o_rdaddress_regout = r_rdaddr;
   assign o_rden_LLR_regout  = r_rden;
   assign o_rden_E_regout    = r_rden;
   assign o_iter_count       = r_iter;
   assign o_busy             = r_busy;
   assign o_done             = r_done;

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Self-checking bench for siso_layer_scheduler.
// A 13-cycle delay line models the row unit loop; a scoreboard of expected
// bursts and done events is filled from a layer/iteration level model.
module tb_siso_layer_scheduler;

   localparam int DEPTH  = 20;
   localparam int LAYERS = 2;
   localparam int GAP    = 14;
   localparam int BUDGET = 3000;

   typedef struct {
      int layer;
      int len;
      int gap;
   } burstExpT;

   typedef struct {
      int iter;
      int underflow;
   } doneExpT;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [4:0] maxIterIn = '0;
   logic       wrenIn = 1'b0;
   logic       forceWren = 1'b0;
   logic [0:0] rdlayer;
   logic [4:0] rdaddr;
   logic       rden;
   logic       rdenE;
   logic [4:0] iterCount;
   logic       busy;
   logic       done;
   logic       errUnderflow;

   logic [13:0] delayLine = '0;

   int checks = 0;
   int failures = 0;
   int stickyExp = 0;
   int eMismatch = 0;

   burstExpT expBurstQ[$];
   doneExpT  expDoneQ[$];

   siso_layer_scheduler dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_abort           (abort),
      .i_max_iter        (maxIterIn),
      .i_wren_in         (wrenIn),
      .o_rdlayer_regout  (rdlayer),
      .o_rdaddress_regout(rdaddr),
      .o_rden_LLR_regout (rden),
      .o_rden_E_regout   (rdenE),
      .o_iter_count      (iterCount),
      .o_busy            (busy),
      .o_done            (done),
      .o_err_underflow   (errUnderflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Row unit model: wren returns 13 cycles after each read, cleared by reset
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            delayLine = '0;
            wrenIn    = forceWren;
         end else begin
            delayLine = {delayLine[12:0], rden};
            wrenIn    = delayLine[13] | forceWren;
         end
      end
   end

   // Monitor: assembles bursts and done pulses and scores them against the queues
   initial begin
      bit inBurst = 0;
      bit addrOk = 1;
      bit prevDone = 0;
      int burstLen = 0;
      int burstLayer = 0;
      int burstGap = 0;
      int gapCnt = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            inBurst  = 0;
            burstLen = 0;
            gapCnt   = 0;
            prevDone = 0;
         end else begin
            if (rdenE !== rden) eMismatch++;
            if (rden) begin
               if (!inBurst) begin
                  inBurst    = 1;
                  burstLen   = 0;
                  burstLayer = int'(rdlayer);
                  burstGap   = gapCnt;
                  addrOk     = 1;
               end
               if (int'(rdaddr) != burstLen || int'(rdlayer) != burstLayer) addrOk = 0;
               burstLen++;
            end else begin
               if (inBurst) begin
                  if (expBurstQ.size() == 0) begin
                     checkOutput("unexpectedBurst", 1, 0);
                  end else begin
                     burstExpT e;
                     e = expBurstQ.pop_front();
                     checkOutput("burstLayer", burstLayer, e.layer);
                     checkOutput("burstLen", burstLen, e.len);
                     checkOutput("burstAddrSeq", int'(addrOk), 1);
                     if (e.gap >= 0) checkOutput("burstGap", burstGap, e.gap);
                  end
                  inBurst = 0;
                  gapCnt  = 0;
               end
               gapCnt++;
            end
            if (done) begin
               if (prevDone) checkOutput("doneWidth", 2, 1);
               if (expDoneQ.size() == 0) begin
                  checkOutput("unexpectedDone", 1, 0);
               end else begin
                  doneExpT d;
                  d = expDoneQ.pop_front();
                  checkOutput("iterCount", int'(iterCount), d.iter);
                  checkOutput("errUnderflowAtDone", int'(errUnderflow), d.underflow);
                  checkOutput("busyAtDone", int'(busy), 0);
               end
            end
            prevDone = done;
         end
      end
   end

   // One decode: model the expected bursts, start, optionally abort/restart, wait for done
   task automatic applyStimulus(input int maxIter, input int abortBurst, input bit restartMid);
      int nIter;
      int nBursts;
      int expIter;
      int issueCount;
      bit seenDone;
      bit abortIssued;
      bit restarted;
      nIter   = (maxIter == 0) ? 1 : maxIter;
      nBursts = (abortBurst >= 0) ? abortBurst + 1 : nIter * LAYERS;
      expIter = (abortBurst >= 0) ? (abortBurst + 1) / LAYERS : nIter;
      for (int b = 0; b < nBursts; b++) begin
         burstExpT e;
         e.layer = b % LAYERS;
         e.len   = DEPTH;
         e.gap   = (b == 0) ? -1 : GAP;
         expBurstQ.push_back(e);
      end
      begin
         doneExpT d;
         d.iter      = expIter;
         d.underflow = stickyExp;
         expDoneQ.push_back(d);
      end
      eMismatch = 0;
      maxIterIn = 5'(maxIter);
      $display("[TB] decode max_iter=%0d abortBurst=%0d restart=%0d", maxIter, abortBurst, restartMid);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busyAfterStart", int'(busy), 1);
      issueCount  = 0;
      seenDone    = 0;
      abortIssued = 0;
      restarted   = 0;
      for (int c = 0; c < BUDGET && !seenDone; c++) begin
         @(negedge clk);
         abort = 1'b0;
         start = 1'b0;
         if (done) seenDone = 1;
         if (rden) begin
            issueCount++;
            if (abortBurst >= 0 && !abortIssued && issueCount == abortBurst * DEPTH + 5) begin
               abort       = 1'b1;
               abortIssued = 1;
            end
            if (restartMid && !restarted && issueCount == 30) begin
               start     = 1'b1;
               restarted = 1;
            end
         end
      end
      abort = 1'b0;
      start = 1'b0;
      if (!seenDone) checkOutput("doneTimeout", 0, 1);
      repeat (3) @(negedge clk);
      checkOutput("burstsLeft", expBurstQ.size(), 0);
      checkOutput("doneLeft", expDoneQ.size(), 0);
      checkOutput("busyIdle", int'(busy), 0);
      checkOutput("rdenEFollowsLLR", eMismatch, 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
      checkOutput({tag, "_rden"}, int'(rden), 0);
      checkOutput({tag, "_rdenE"}, int'(rdenE), 0);
      checkOutput({tag, "_iter"}, int'(iterCount), 0);
      checkOutput({tag, "_underflow"}, int'(errUnderflow), 0);
      checkOutput({tag, "_addr"}, int'(rdaddr), 0);
      checkOutput({tag, "_layer"}, int'(rdlayer), 0);
   endtask

   initial begin
      int idle;
      int cnt;
      int m;
      int ab;
      int nI;
      bit rs;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal two-iteration decode, then max_iter=0, abort, ignored restart
      applyStimulus(2, -1, 1'b0);
      applyStimulus(0, -1, 1'b0);
      applyStimulus(2, 0, 1'b0);
      applyStimulus(2, -1, 1'b1);

      // Asynchronous reset while layer 0 writes are still draining
      maxIterIn = 5'd2;
      expBurstQ.push_back('{layer: 0, len: DEPTH, gap: -1});
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt  = 0;
      idle = 0;
      for (int c = 0; c < BUDGET && idle < 7; c++) begin
         @(negedge clk);
         if (rden) cnt++;
         else if (cnt >= DEPTH) idle++;
      end
      checkOutput("reachedWait", int'(idle == 7), 1);
      #3;
      rst = 1'b0;
      #1;
      checkResetOutputs("asyncReset");
      expBurstQ.delete();
      expDoneQ.delete();
      stickyExp = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(2, -1, 1'b0);

      // Write return while idle: sticky underflow, decode still completes
      @(negedge clk);
      forceWren = 1'b1;
      repeat (3) @(negedge clk);
      forceWren = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("underflowSet", int'(errUnderflow), 1);
      checkOutput("underflowBusy", int'(busy), 0);
      stickyExp = 1;
      repeat (3) @(negedge clk);
      checkOutput("underflowSticky", int'(errUnderflow), 1);
      applyStimulus(1, -1, 1'b0);

      // Randomized decodes
      for (int r = 0; r < 5; r++) begin
         m  = int'($urandom_range(0, 3));
         nI = (m == 0) ? 1 : m;
         ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nI * LAYERS - 1)) : -1;
         rs = 1'($urandom_range(0, 1));
         repeat (int'($urandom_range(1, 5))) @(negedge clk);
         applyStimulus(m, ab, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/siso_layer_scheduler.md
Name: siso_layer_scheduler

Overview:
- Sequences the pipelined SISO row unit for layered decoding.
- Issues per-layer read address/enable streams (rdlayer/rdaddress/rden_LLR/rden_E) for every layer of every iteration.
- Tracks outstanding pipeline writes by counting issued reads against the row unit's registered wren, and holds the next layer until the previous layer's writes have drained (read-after-write hazard on L-memory).
- Sits between the decoder top-level control and the row unit's *_regin inputs.

Parameters:
LAYERS, 2, number of layers per iteration (row unit layer select is 1 bit, so LAYERS<=2**LAYERBITS)
LAYERBITS, 1, width of rdlayer
ADDRWIDTH, 5, L/E memory address width per layer
ADDRDEPTH, 20, addresses per layer, ceil(Z/P)
ITERWIDTH, 5, width of iteration count and max_iter
CNTWIDTH, 6, outstanding-write counter width; must hold ADDRDEPTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a decode when idle
abort  in  1  early-termination request (e.g. syndrome check passed)
max_iter  in  ITERWIDTH  iterations to run; 0 treated as 1
wren_in  in  1  row unit registered wren (one pulse per completed write)
rdlayer_regout  out  LAYERBITS  layer select to row unit
rdaddress_regout  out  ADDRWIDTH  read address to row unit
rden_LLR_regout  out  1  L-memory read enable / valid
rden_E_regout  out  1  E-memory read enable
iter_count  out  ITERWIDTH  completed iterations
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of decode
err_underflow  out  1  sticky: wren_in seen with zero outstanding

Behaviour:
- Reset (async, rst=0): all outputs 0, FSM=IDLE, outstanding=0, layer=0, address=0. Reset mid-decode aborts immediately; there is no drain.
- All outputs are registered. rden_E_regout always equals rden_LLR_regout; E-memory is cleared at reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 -> ISSUE; busy=1 from the next cycle; iter_count=0; layer=0; address=0.
  - start while busy is ignored.
- ISSUE:
  - Each cycle drives rden=1, rdlayer=layer, rdaddress=address, then increments address.
  - The cycle with address==ADDRDEPTH-1 is the last issue; next state WAIT; address wraps to 0.
  - Exactly ADDRDEPTH consecutive valid cycles per layer, no bubbles.
- WAIT:
  - rden=0.
  - When outstanding==0 after this cycle's update:
    - If layer<LAYERS-1: layer+1, go to ISSUE.
    - Else (last layer): iter_count+1, layer=0. If the new iter_count==max(max_iter,1) or abort was latched -> DONE; otherwise -> ISSUE.
- Outstanding counter:
  - +1 on each issued rden, -1 on each wren_in; both in the same cycle leaves it unchanged.
  - wren_in with outstanding==0: counter stays 0, err_underflow set (cleared only by reset).
- Abort:
  - Latched when it occurs in ISSUE or WAIT.
  - Issue continues to the end of the current layer, so the layer completes fully.
  - The FSM then waits for drain and goes to DONE without starting another layer.
  - Abort in IDLE is ignored. The latch clears on entering IDLE.
- DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE. iter_count holds its value until the next start.
- Timing: with row-unit loop latency Lp (rden_regin to wren, 13 cycles nominal), the gap between the last issue of layer k and the first issue of layer k+1 is Lp+1 cycles. The scheduler does not encode Lp; it depends only on wren_in.
- Simultaneous start and DONE: start is ignored, since the FSM is not in IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the LAYERBITS/ADDRWIDTH/ADDRDEPTH defaults shared with the row unit and E-memory.
- One natural sub-module: siso_outstanding_cnt (up/down counter with zero flag and underflow flag), reused for any future multi-row-unit scheduler.

Test Plan:
- Bench uses a 13-cycle delay line from rden_LLR_regout to wren_in, with defaults and max_iter=2. Required: 4 layer bursts of exactly 20 cycles; layers 0,1,0,1; gap of 14 idle rden cycles between bursts; done pulses once; iter_count=2; err_underflow=0.
- max_iter=0 -> exactly one iteration (2 bursts), iter_count=1, done pulse.
- abort pulsed at the 5th issue cycle of layer 0, iteration 0 -> layer 0 completes (20 issues), no layer 1 burst, done once outstanding returns to 0, iter_count=0.
- start re-pulsed mid-decode -> ignored: burst count and iter_count identical to the first scenario.
- Async reset asserted during a WAIT with outstanding=7 -> all outputs 0 immediately without a clock edge; a new start after release runs cleanly.
- wren_in forced high in IDLE -> err_underflow=1 and sticky; outstanding stays 0; the next decode still completes.
